// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch (read-only)
// and the load/store unit (read/write).
//
// A requester holds its request until it sees its ack. The arbiter grants
// the bus to one requester at a time and routes mem_rdata/mem_ack back to
// the owner. A grant is never preempted and always ends on mem_ack, even if
// the requester has dropped its request. Each grant is followed by one
// mandatory IDLE cycle. Only state and last_grant are registered. All bus and
// requester outputs are decoded combinationally from state, so asserting
// reset_n low forces every output to zero at once.
//
// Optional feature, selected by the macro ARB_ROUND_ROBIN_EN:
//   defined   - simultaneous requests go to the requester not granted last
//               (LSU first after reset).
//   undefined - fixed priority: the LSU always wins simultaneous requests.
//               last_grant is still tracked but does not affect grants.

module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,

    // Instruction fetch port (read-only)
    input  logic            ifu_re,
    input  logic [XLEN-1:0] ifu_addr,
    input  logic [3:0]      ifu_sel,
    output logic [XLEN-1:0] ifu_rdata,
    output logic            ifu_ack,

    // Load/store port
    input  logic            lsu_re,
    input  logic            lsu_we,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [3:0]      lsu_sel,
    input  logic [XLEN-1:0] lsu_wdata,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            lsu_ack,

    // Shared memory bus
    output logic            mem_re,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_sel,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IFU = 2'd1,
        GNT_LSU = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t state;
    owner_t last_grant;

    logic ifu_req;
    logic lsu_req;
    logic lsu_wins;

    assign ifu_req = ifu_re;
    assign lsu_req = lsu_re | lsu_we;

    // Tie-break used only when both requesters ask in the same IDLE cycle.
`ifdef ARB_ROUND_ROBIN_EN
    assign lsu_wins = (last_grant == OWN_IFU);
`else
    assign lsu_wins = 1'b1;
`endif

    // Grant FSM: choose an owner in IDLE, then hold the grant until mem_ack.
    // NOTE: sequential state uses non-blocking (<=) assignments, so every
    // register samples values from before the clock edge. Blocking
    // assignments here would let later statements see already-updated state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= OWN_IFU;
        end else begin
            last_grant <= last_grant;
            case (state)
                IDLE: begin
                    if (ifu_req && lsu_req) begin
                        state <= lsu_wins ? GNT_LSU : GNT_IFU;
                    end else if (lsu_req) begin
                        state <= GNT_LSU;
                    end else if (ifu_req) begin
                        state <= GNT_IFU;
                    end else begin
                        state <= IDLE;
                    end
                end
                GNT_IFU: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        last_grant <= OWN_IFU;
                    end
                end
                GNT_LSU: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        last_grant <= OWN_LSU;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode: drive the bus from the owner and route rdata/ack back.
    // NOTE: every output gets a default before the case, so no path leaves an
    // output unassigned. An unassigned path would infer a latch.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_sel   = 4'b0000;
        mem_wdata = '0;
        ifu_rdata = '0;
        ifu_ack   = 1'b0;
        lsu_rdata = '0;
        lsu_ack   = 1'b0;
        case (state)
            GNT_IFU: begin
                mem_re    = 1'b1;
                mem_addr  = ifu_addr;
                mem_sel   = ifu_sel;
                ifu_rdata = mem_rdata;
                ifu_ack   = mem_ack;
            end
            GNT_LSU: begin
                // A write takes precedence when lsu_re and lsu_we are both high.
                mem_we    = lsu_we;
                mem_re    = ~lsu_we;
                mem_addr  = lsu_addr;
                mem_sel   = lsu_sel;
                mem_wdata = lsu_wdata;
                lsu_rdata = mem_rdata;
                lsu_ack   = mem_ack;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, self-checking bench for mem_arbiter.
// Each expected bus transaction is pushed to a scoreboard when its request
// is driven. It is popped and compared while the DUT holds the grant and
// returns the ack. The contention expectations follow ARB_ROUND_ROBIN_EN.

module tb_mem_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ifu_re;
    logic [XLEN-1:0] ifu_addr;
    logic [3:0]      ifu_sel;
    logic [XLEN-1:0] ifu_rdata;
    logic            ifu_ack;
    logic            lsu_re;
    logic            lsu_we;
    logic [XLEN-1:0] lsu_addr;
    logic [3:0]      lsu_sel;
    logic [XLEN-1:0] lsu_wdata;
    logic [XLEN-1:0] lsu_rdata;
    logic            lsu_ack;
    logic            mem_re;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_sel;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    // One expected bus transaction: its owner and what must appear on the bus.
    typedef struct {
        logic        lsu;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ifu_re    (ifu_re),
        .ifu_addr  (ifu_addr),
        .ifu_sel   (ifu_sel),
        .ifu_rdata (ifu_rdata),
        .ifu_ack   (ifu_ack),
        .lsu_re    (lsu_re),
        .lsu_we    (lsu_we),
        .lsu_addr  (lsu_addr),
        .lsu_sel   (lsu_sel),
        .lsu_wdata (lsu_wdata),
        .lsu_rdata (lsu_rdata),
        .lsu_ack   (lsu_ack),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_sel   (mem_sel),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The arbiter must present a quiet bus and quiet requester outputs.
    task automatic check_idle(input string tag);
        check({tag, " strobes/acks"}, {28'd0, mem_re, mem_we, ifu_ack, lsu_ack}, 32'd0);
        check({tag, " mem_addr"}, mem_addr, 32'd0);
        check({tag, " data/sel"}, mem_wdata | ifu_rdata | lsu_rdata | {28'd0, mem_sel}, 32'd0);
    endtask

    task automatic push_ifu(input logic [31:0] addr, input logic [3:0] sel);
        exp_t e;
        e.lsu = 1'b0; e.we = 1'b0; e.addr = addr; e.sel = sel; e.wdata = 32'd0;
        sb.push_back(e);
    endtask

    task automatic push_lsu(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata);
        exp_t e;
        e.lsu = 1'b1; e.we = we; e.addr = addr; e.sel = sel; e.wdata = wdata;
        sb.push_back(e);
    endtask

    // Called during the first checked cycle of a grant. It holds the grant
    // for 'waits' cycles without an ack, then acks with 'rdata'. It returns
    // in the following IDLE cycle.
    task automatic serve(input string tag, input int waits, input logic [31:0] rdata);
        exp_t e;
        check({tag, " scoreboard nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, " mem_addr"}, mem_addr, e.addr);
        check({tag, " mem_sel"}, {28'd0, mem_sel}, {28'd0, e.sel});
        check({tag, " mem_wdata"}, mem_wdata, e.wdata);
        for (int i = 0; i < waits; i++) begin
            mem_ack = 1'b0;
            #1;
            check({tag, " strobes in wait"}, {30'd0, mem_re, mem_we}, {30'd0, ~e.we, e.we});
            check({tag, " no ack in wait"}, {30'd0, ifu_ack, lsu_ack}, 32'd0);
            tick();
        end
        check({tag, " strobes"}, {30'd0, mem_re, mem_we}, {30'd0, ~e.we, e.we});
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        #1;
        check({tag, " acks"}, {30'd0, ifu_ack, lsu_ack}, {30'd0, ~e.lsu, e.lsu});
        check({tag, " ifu_rdata"}, ifu_rdata, e.lsu ? 32'd0 : rdata);
        check({tag, " lsu_rdata"}, lsu_rdata, e.lsu ? rdata : 32'd0);
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        #1;
        check_idle({tag, " idle after ack"});
    endtask

    initial begin
        reset_n   = 1'b0;
        ifu_re    = 1'b0;
        ifu_addr  = 32'd0;
        ifu_sel   = 4'b0000;
        lsu_re    = 1'b0;
        lsu_we    = 1'b0;
        lsu_addr  = 32'd0;
        lsu_sel   = 4'b0000;
        lsu_wdata = 32'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;

        // Reset state
        #12;
        check_idle("reset");
        reset_n = 1'b1;
        tick();
        check_idle("post-reset");

        // Single fetch with two wait cycles. The request stays high through
        // the ack edge and must not be regranted in the following cycle.
        ifu_re   = 1'b1;
        ifu_addr = 32'h0000_0100;
        ifu_sel  = 4'b1111;
        push_ifu(32'h0000_0100, 4'b1111);
        tick();
        serve("fetch", 2, 32'hDEAD_BEEF);
        ifu_re = 1'b0;
        tick();
        check_idle("fetch done");

        // Fetch dropped before ack: the grant stays until mem_ack.
        ifu_re   = 1'b1;
        ifu_addr = 32'h0000_0140;
        push_ifu(32'h0000_0140, 4'b1111);
        tick();
        ifu_re = 1'b0;
        tick();
        serve("fetch dropped", 1, 32'h1234_5678);

        // LSU byte write
        lsu_we    = 1'b1;
        lsu_addr  = 32'h0000_2003;
        lsu_sel   = 4'b0001;
        lsu_wdata = 32'h0000_00AB;
        push_lsu(1'b1, 32'h0000_2003, 4'b0001, 32'h0000_00AB);
        tick();
        serve("lsu write", 1, 32'h0BAD_F00D);
        lsu_we = 1'b0;

        // lsu_re and lsu_we together: the write wins.
        lsu_re    = 1'b1;
        lsu_we    = 1'b1;
        lsu_addr  = 32'h0000_2100;
        lsu_sel   = 4'b1111;
        lsu_wdata = 32'hCAFE_0001;
        push_lsu(1'b1, 32'h0000_2100, 4'b1111, 32'hCAFE_0001);
        tick();
        serve("lsu re+we", 0, 32'h0000_0055);
        lsu_re = 1'b0;
        lsu_we = 1'b0;

        // Spurious mem_ack in IDLE with no requests
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        check_idle("spurious ack");
        tick();
        check_idle("spurious ack next");
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;

        // Reset asserted during an LSU wait, then a fetch once reset is released
        lsu_re    = 1'b1;
        lsu_addr  = 32'h0000_3000;
        lsu_sel   = 4'b0011;
        lsu_wdata = 32'h0000_0000;
        tick();
        check("mid-reset granted", {31'd0, mem_re}, 32'd1);
        #2;
        mem_ack = 1'b1;
        reset_n = 1'b0;
        #1;
        check_idle("async reset");
        lsu_re   = 1'b0;
        mem_ack  = 1'b0;
        ifu_re   = 1'b1;
        ifu_addr = 32'h0000_0400;
        push_ifu(32'h0000_0400, 4'b1111);
        tick();
        check_idle("held in reset");
        #2;
        reset_n = 1'b1;
        tick();
        serve("fetch after reset", 0, 32'h0000_0400);
        ifu_re = 1'b0;

        // Contention: both requests held, zero-wait memory
        ifu_re    = 1'b1;
        ifu_addr  = 32'h0000_1000;
        ifu_sel   = 4'b1111;
        lsu_re    = 1'b1;
        lsu_addr  = 32'h0000_2000;
        lsu_sel   = 4'b1100;
        lsu_wdata = 32'h0000_0077;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (i % 2 == 0) push_lsu(1'b0, 32'h0000_2000, 4'b1100, 32'h0000_0077);
            else            push_ifu(32'h0000_1000, 4'b1111);
`else
            push_lsu(1'b0, 32'h0000_2000, 4'b1100, 32'h0000_0077);
`endif
            tick();
            serve($sformatf("contention %0d", i), 0, 32'hA000_0000 + i);
        end
        ifu_re = 1'b0;
        lsu_re = 1'b0;
        tick();
        check_idle("final idle");
        check("scoreboard drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the core's single memory bus between instruction fetch (read-only) and the load/store unit (read/write). It sits between the fetch unit / LSU and the external bus. Each requester holds its request until it sees ack; the arbiter serialises requests and routes data and ack back to the requester that owns the bus.

## Interface
- XLEN, 32, address/data width
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- ifu_re  input  1  fetch read request, held until ifu_ack
- ifu_addr  input  XLEN  fetch address
- ifu_sel  input  4  fetch byte lanes
- ifu_rdata  output  XLEN  read data to fetch
- ifu_ack  output  1  fetch transfer complete
- lsu_re / lsu_we  input  1 each  LSU read / write request, held until lsu_ack
- lsu_addr  input  XLEN  LSU address
- lsu_sel  input  4  LSU byte lanes
- lsu_wdata  input  XLEN  LSU write data
- lsu_rdata  output  XLEN  read data to LSU
- lsu_ack  output  1  LSU transfer complete
- mem_re / mem_we  output  1 each  bus read / write strobe
- mem_addr  output  XLEN  bus address
- mem_sel  output  4  bus byte lanes
- mem_wdata  output  XLEN  bus write data
- mem_rdata  input  XLEN  bus read data
- mem_ack  input  1  bus transfer complete

## Operation
- States: IDLE, GNT_IFU, GNT_LSU; state and last_grant registered, everything else combinational from state.
- IDLE: all mem_* outputs 0, both acks 0, both rdata 0. Request sampled at clk edge: only ifu_re -> GNT_IFU; only lsu_re|lsu_we -> GNT_LSU; both -> per arbitration policy (Configuration). Neither -> stay IDLE.
- GNT_IFU: mem_re=1, mem_we=0, mem_addr=ifu_addr, mem_sel=ifu_sel, mem_wdata=0; ifu_rdata=mem_rdata; ifu_ack=mem_ack; LSU outputs 0.
- GNT_LSU: mem_addr=lsu_addr, mem_sel=lsu_sel, mem_wdata=lsu_wdata, lsu_rdata=mem_rdata, lsu_ack=mem_ack; IFU outputs 0. lsu_we=1 -> mem_we=1, mem_re=0 (write wins if both lsu_re and lsu_we high); else mem_re=1.
- GNT_x with mem_ack=1 -> IDLE next cycle, last_grant<=x. No ack -> remain; grant never preempted.
- Requester dropping its request before ack: arbiter stays in GNT_x until mem_ack (bus transaction cannot be abandoned).
- mem_ack in IDLE: ignored, no ack forwarded.
- Reset (any cycle, incl. mid-transaction): state<=IDLE, last_grant<=IFU; all outputs 0 immediately.

## Timing
- Request-to-bus latency: 1 cycle (request seen in IDLE at edge N, mem strobe high in cycle N+1).
- mem_ack -> requester ack: 0 cycles (combinational); mem_rdata -> rdata: 0 cycles.
- Mandatory one IDLE cycle after every ack; requester's stale request in the ack cycle is never regranted. Minimum transaction: 3 cycles (IDLE, GNT with ack, IDLE); back-to-back same-requester throughput 1 per 2 cycles with zero-wait memory.
- Acks are single-cycle pulses coincident with mem_ack.

## Configuration
- ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE go to the requester not equal to last_grant (after reset, LSU first since last_grant resets to IFU).
- Not defined: fixed priority, LSU always wins simultaneous requests; last_grant still tracked but unused. Single-requester behaviour identical in both builds.

## Test plan
- Single fetch: ifu_re=1, ifu_addr=0x100, mem_ack after 2 wait cycles, mem_rdata=0xDEADBEEF -> mem_re=1 addr 0x100 from cycle 1, ifu_ack pulse with ifu_rdata=0xDEADBEEF, IDLE next cycle.
- LSU byte write: lsu_we=1, addr=0x2003, sel=0001, wdata=0xAB -> mem_we=1, mem_re=0, mem_sel=0001, mem_wdata=0xAB until ack; lsu_ack pulse; ifu outputs stay 0.
- Contention: ifu_re and lsu_re both held continuously, zero-wait memory -> fixed build: LSU granted every time; RR build: grants alternate LSU, IFU, LSU, IFU.
- Both lsu_re=1 and lsu_we=1 -> mem_we=1, mem_re=0.
- Spurious mem_ack=1 in IDLE with no requests -> ifu_ack=lsu_ack=0, state stays IDLE.
- reset_n low during GNT_LSU wait -> all mem_* and acks 0 asynchronously; after release with ifu_re=1 -> GNT_IFU one cycle later.
